ddr2_init_sequencer: RTL and testbench

DDR2_INIT_SEQUENCER -- requirements
Module: ddr2_init_sequencer

---
 rtl/ddr2_pkg.sv | 59 +++++
 rtl/ddr2_init_timer.sv | 29 ++
 rtl/ddr2_init_sequencer.sv | 165 ++++++++++++++++
 tb/tb_ddr2_init_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ddr2_pkg.sv
// Shared DDR2 init definitions: command codes, sequencer states, mode-register bank
// selects and the OCD field values used during the JEDEC power-up sequence.
package ddr2_pkg;

   localparam int unsigned CMD_W   = 3;
   localparam int unsigned BA_W    = 2;
   localparam int unsigned ADDR_W  = 13;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned ST_W    = 4;
   localparam int unsigned A8_BIT  = 8;
   localparam int unsigned A10_BIT = 10;

   typedef enum logic [CMD_W-1:0] {
      CMD_NOP           = 3'b000,
      CMD_REFRESH       = 3'b001,
      CMD_PRECHARGE_ALL = 3'b010,
      CMD_LOAD_MODE     = 3'b011
   } ddr2_cmd_e;

   typedef enum logic [ST_W-1:0] {
      ST_WAIT200,
      ST_PRE_GUARD,
      ST_EMR2,
      ST_EMR3,
      ST_EMR1_DLL,
      ST_MR_DLLRST,
      ST_PRE_ALL,
      ST_REF1,
      ST_REF2,
      ST_MR_NORM,
      ST_OCD_DEF,
      ST_OCD_EXIT,
      ST_DONE
   } ddr2_state_e;

   localparam logic [BA_W-1:0] BA_MR   = 2'b00;
   localparam logic [BA_W-1:0] BA_EMR1 = 2'b01;
   localparam logic [BA_W-1:0] BA_EMR2 = 2'b10;
   localparam logic [BA_W-1:0] BA_EMR3 = 2'b11;

   localparam logic [2:0] OCD_FIELD_DEFAULT = 3'b111;
   localparam logic [2:0] OCD_FIELD_EXIT    = 3'b000;

   typedef struct packed {
      ddr2_cmd_e             cmd;
      logic [BA_W-1:0]       ba;
      logic [ADDR_W-1:0]     addr;
   } ddr2_cmd_t;

   // Replace EMR1 A9:A7 (OCD calibration program field) with the given value.
   function automatic logic [ADDR_W-1:0] with_ocd(input logic [ADDR_W-1:0] emr1,
                                                  input logic [2:0]        field);
      logic [ADDR_W-1:0] v;
      v      = emr1;
      v[9:7] = field;
      return v;
   endfunction

endpackage

// File: rtl/ddr2_init_timer.sv
// Loadable 16-bit down-counter that saturates at zero and flags when it gets there.
module ddr2_init_timer
   import ddr2_pkg::*;
#(
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             CLK_in,
   input  logic             RST_in,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge CLK_in or posedge RST_in) begin
      if (RST_in) begin
         count_q <= RST_VAL;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - CNT_W'(1);
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/ddr2_init_sequencer.sv
// DDR2 power-up initialisation sequencer: waits for stable clock, then issues the
// precharge / EMR / MR / refresh / OCD command stream and waits for DLL lock.
module ddr2_init_sequencer
   import ddr2_pkg::*;
#(
   parameter int unsigned       WAIT_CYCLES      = 26667,
   parameter int unsigned       PRE_GUARD_CYCLES = 8,
   parameter int unsigned       TMRD_CYCLES      = 2,
   parameter int unsigned       TRP_CYCLES       = 3,
   parameter int unsigned       TRFC_CYCLES      = 14,
   parameter int unsigned       DLL_LOCK_CYCLES  = 200,
   parameter logic [ADDR_W-1:0] MR_VAL           = 13'h0232,
   parameter logic [ADDR_W-1:0] EMR1_VAL         = 13'h0004
) (
   input  logic              CLK_in,
   input  logic              RST_in,
   output logic              CKE_out,
   output logic              WAIT200_DONE_out,
   output logic              INIT_DONE_out,
   output logic [CMD_W-1:0]  INIT_CMD_out,
   output logic [BA_W-1:0]   INIT_BA_out,
   output logic [ADDR_W-1:0] INIT_ADDR_out
);

   ddr2_state_e      state_q;
   ddr2_state_e      next_state;
   ddr2_cmd_t        cmd_q;
   logic             cke_q;
   logic             wait_done_q;
   logic             init_done_q;
   logic             gap_zero;
   logic             dll_zero;
   logic             advance;
   logic             dll_load;
   logic [CNT_W-1:0] gap_val;

   // Total cycles spent in a state: the command cycle plus its trailing NOP gap.
   function automatic int unsigned state_cycles(input ddr2_state_e s);
      case (s)
         ST_PRE_GUARD:            return PRE_GUARD_CYCLES;
         ST_PRE_ALL:              return 1 + TRP_CYCLES;
         ST_REF1, ST_REF2:        return 1 + TRFC_CYCLES;
         ST_EMR2, ST_EMR3, ST_EMR1_DLL, ST_MR_DLLRST,
         ST_MR_NORM, ST_OCD_DEF, ST_OCD_EXIT:
                                  return 1 + TMRD_CYCLES;
         default:                 return 1;
      endcase
   endfunction

   // Command word issued on the first cycle of a state.
   function automatic ddr2_cmd_t state_cmd(input ddr2_state_e s);
      ddr2_cmd_t c;
      c = '0;
      case (s)
         ST_EMR2: begin
            c.cmd = CMD_LOAD_MODE;
            c.ba  = BA_EMR2;
         end
         ST_EMR3: begin
            c.cmd = CMD_LOAD_MODE;
            c.ba  = BA_EMR3;
         end
         ST_EMR1_DLL: begin
            c.cmd  = CMD_LOAD_MODE;
            c.ba   = BA_EMR1;
            c.addr = EMR1_VAL;
         end
         ST_MR_DLLRST: begin
            c.cmd          = CMD_LOAD_MODE;
            c.ba           = BA_MR;
            c.addr         = MR_VAL;
            c.addr[A8_BIT] = 1'b1;
         end
         ST_PRE_ALL: begin
            c.cmd           = CMD_PRECHARGE_ALL;
            c.addr[A10_BIT] = 1'b1;
         end
         ST_REF1, ST_REF2: begin
            c.cmd = CMD_REFRESH;
         end
         ST_MR_NORM: begin
            c.cmd          = CMD_LOAD_MODE;
            c.ba           = BA_MR;
            c.addr         = MR_VAL;
            c.addr[A8_BIT] = 1'b0;
         end
         ST_OCD_DEF: begin
            c.cmd  = CMD_LOAD_MODE;
            c.ba   = BA_EMR1;
            c.addr = with_ocd(EMR1_VAL, OCD_FIELD_DEFAULT);
         end
         ST_OCD_EXIT: begin
            c.cmd  = CMD_LOAD_MODE;
            c.ba   = BA_EMR1;
            c.addr = with_ocd(EMR1_VAL, OCD_FIELD_EXIT);
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Leave OCD_EXIT only once both its gap and the DLL lock interval are over.
   always_comb begin
      next_state = ST_DONE;
      if (state_q != ST_DONE) begin
         next_state = ddr2_state_e'(ST_W'(state_q) + ST_W'(1));
      end
      advance  = gap_zero && (state_q != ST_DONE) &&
                 ((state_q != ST_OCD_EXIT) || dll_zero);
      gap_val  = CNT_W'(state_cycles(next_state) - 1);
      dll_load = advance && (next_state == ST_MR_DLLRST);
   end

   ddr2_init_timer #(
      .RST_VAL (CNT_W'(WAIT_CYCLES - 1))
   ) u_gap_timer (
      .CLK_in   (CLK_in),
      .RST_in   (RST_in),
      .load     (advance),
      .load_val (gap_val),
      .dec      (1'b1),
      .zero     (gap_zero)
   );

   ddr2_init_timer #(
      .RST_VAL (CNT_W'(DLL_LOCK_CYCLES - 1))
   ) u_dll_timer (
      .CLK_in   (CLK_in),
      .RST_in   (RST_in),
      .load     (dll_load),
      .load_val (CNT_W'(DLL_LOCK_CYCLES - 1)),
      .dec      (1'b1),
      .zero     (dll_zero)
   );

   always_ff @(posedge CLK_in or posedge RST_in) begin
      if (RST_in) begin
         state_q     <= ST_WAIT200;
         cmd_q       <= '0;
         cke_q       <= 1'b0;
         wait_done_q <= 1'b0;
         init_done_q <= 1'b0;
      end else if (advance) begin
         state_q <= next_state;
         cmd_q   <= state_cmd(next_state);
         if (next_state == ST_PRE_GUARD) begin
            cke_q       <= 1'b1;
            wait_done_q <= 1'b1;
         end
         if (next_state == ST_DONE) begin
            init_done_q <= 1'b1;
         end
      end else begin
         cmd_q <= '0;
      end
   end

   assign CKE_out          = cke_q;
   assign WAIT200_DONE_out = wait_done_q;
   assign INIT_DONE_out    = init_done_q;
   assign INIT_CMD_out     = cmd_q.cmd;
   assign INIT_BA_out      = cmd_q.ba;
   assign INIT_ADDR_out    = cmd_q.addr;

endmodule

// File: tb/tb_ddr2_init_sequencer.sv
// Bench for ddr2_init_sequencer: schedule model checked every cycle on two instances
// (normal DLL lock and DLL_LOCK_CYCLES=1) plus directed literal checks and resets.
module tb_ddr2_init_sequencer;

   localparam int WAIT = 20;
   localparam int PG   = 8;
   localparam logic [12:0] MR   = 13'h0232;
   localparam logic [12:0] EMR1 = 13'h0004;

   // Command stream in issue order with its trailing gap.
   localparam logic [2:0]  S_CMD  [10] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3};
   localparam logic [1:0]  S_BA   [10] = '{2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
   localparam logic [12:0] S_ADDR [10] = '{13'h0, 13'h0, EMR1, MR | 13'h0100, 13'h0400, 13'h0, 13'h0,
                                           MR & ~13'h0100, EMR1 | 13'h0380, EMR1 & ~13'h0380};
   localparam int          S_GAP  [10] = '{2, 2, 2, 2, 3, 14, 14, 2, 2, 2};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cke_a, w200_a, done_a, cke_b, w200_b, done_b;
   logic [2:0]  cmd_a, cmd_b;
   logic [1:0]  ba_a, ba_b;
   logic [12:0] addr_a, addr_b;

   int checks   = 0;
   int failures = 0;
   int e        = 0;

   always #5 clk = ~clk;

   ddr2_init_sequencer #(.WAIT_CYCLES(WAIT), .DLL_LOCK_CYCLES(200)) u_dut (
      .CLK_in(clk), .RST_in(rst), .CKE_out(cke_a), .WAIT200_DONE_out(w200_a),
      .INIT_DONE_out(done_a), .INIT_CMD_out(cmd_a), .INIT_BA_out(ba_a), .INIT_ADDR_out(addr_a));

   ddr2_init_sequencer #(.WAIT_CYCLES(WAIT), .DLL_LOCK_CYCLES(1)) u_dut_fast (
      .CLK_in(clk), .RST_in(rst), .CKE_out(cke_b), .WAIT200_DONE_out(w200_b),
      .INIT_DONE_out(done_b), .INIT_CMD_out(cmd_b), .INIT_BA_out(ba_b), .INIT_ADDR_out(addr_b));

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s edge=%0d got=%0h expected=%0h", name, e, got, exp);
      end
   endtask

   // Edge at which issue number idx appears on the outputs.
   function automatic int issue_edge(input int idx);
      int t = WAIT + PG;
      for (int i = 0; i < idx; i++) t += 1 + S_GAP[i];
      return t;
   endfunction

   function automatic int done_edge(input int dll);
      int t_end = issue_edge(10);
      int t_dll = issue_edge(3) + dll;
      return (t_end > t_dll) ? t_end : t_dll;
   endfunction

   task automatic compare_dut(input string tag, input int dll, input logic cke, input logic w200,
                              input logic done, input logic [2:0] cmd, input logic [1:0] ba,
                              input logic [12:0] addr);
      logic [2:0]  x_cmd  = 3'd0;
      logic [1:0]  x_ba   = 2'd0;
      logic [12:0] x_addr = 13'd0;
      for (int i = 0; i < 10; i++) begin
         if (e == issue_edge(i)) begin
            x_cmd  = S_CMD[i];
            x_ba   = S_BA[i];
            x_addr = S_ADDR[i];
         end
      end
      check({tag, ".cke"},  int'(cke),  int'(e >= WAIT));
      check({tag, ".w200"}, int'(w200), int'(e >= WAIT));
      check({tag, ".done"}, int'(done), int'(e >= done_edge(dll)));
      check({tag, ".cmd"},  int'(cmd),  int'(x_cmd));
      check({tag, ".ba"},   int'(ba),   int'(x_ba));
      check({tag, ".addr"}, int'(addr), int'(x_addr));
   endtask

   // Every cycle after reset release: compare both instances with the model.
   always @(posedge clk) begin
      if (rst) begin
         e = 0;
      end else begin
         #1;
         if (!rst) begin
            e = e + 1;
            compare_dut("dut",  200, cke_a, w200_a, done_a, cmd_a, ba_a, addr_a);
            compare_dut("fast", 1,   cke_b, w200_b, done_b, cmd_b, ba_b, addr_b);
         end
      end
   end

   task automatic wait_edge(input int n);
      int guard = 0;
      while (e != n) begin
         @(posedge clk);
         #2;
         guard++;
         if (guard > 2000) begin
            check("wait_edge_timeout", e, n);
            return;
         end
      end
   endtask

   task automatic check_all_reset(input string tag);
      check({tag, ".cke"},   int'(cke_a | cke_b),   0);
      check({tag, ".w200"},  int'(w200_a | w200_b), 0);
      check({tag, ".done"},  int'(done_a | done_b), 0);
      check({tag, ".cmd"},   int'(cmd_a | cmd_b),   0);
      check({tag, ".ba"},    int'(ba_a | ba_b),     0);
      check({tag, ".addr"},  int'(addr_a | addr_b), 0);
   endtask

   initial begin
      // Pin the model's schedule to hand-derived edges.
      check("model.edge_emr2",   issue_edge(0), 28);
      check("model.edge_dllrst", issue_edge(3), 37);
      check("model.edge_ref1",   issue_edge(5), 44);
      check("model.edge_ocdx",   issue_edge(9), 80);
      check("model.done200",     done_edge(200), 237);
      check("model.done1",       done_edge(1), 83);

      repeat (3) @(posedge clk);
      #1 check_all_reset("rst0");
      @(negedge clk) rst = 1'b0;

      wait_edge(19);
      check("lit.cke19", int'(cke_a), 0);
      wait_edge(20);
      check("lit.cke20", int'(cke_a), 1);
      wait_edge(37);
      check("lit.dllrst_cmd",  int'(cmd_a), 3);
      check("lit.dllrst_addr", int'(addr_a), 'h0332);
      wait_edge(40);
      check("lit.preall_addr", int'(addr_a), 'h0400);
      wait_edge(77);
      check("lit.ocddef_addr", int'(addr_a), 'h0384);
      check("lit.ocddef_ba",   int'(ba_a), 1);
      wait_edge(82);
      check("lit.fast_done82", int'(done_b), 0);
      wait_edge(83);
      check("lit.fast_done83", int'(done_b), 1);
      wait_edge(236);
      check("lit.done236", int'(done_a), 0);
      wait_edge(237);
      check("lit.done237", int'(done_a), 1);
      wait_edge(260);

      // Reset while in DONE.
      @(negedge clk);
      rst = 1'b1;
      #1 check_all_reset("rst_done");
      @(negedge clk) rst = 1'b0;

      // Reset mid REF1 gap, asserted between edges.
      wait_edge(50);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_all_reset("rst_ref1");
      @(negedge clk) rst = 1'b0;
      wait_edge(19);
      check("lit.rerun_cke19", int'(w200_a), 0);
      wait_edge(20);
      check("lit.rerun_cke20", int'(w200_a), 1);
      wait_edge(30);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
